// File: rtl/scan_loader_if.sv
// Host-side handshake bundle for scan_loader: request, byte stream in, readback stream out.
interface scan_loader_if #(
  parameter int buffer_width = 8,
  parameter int addr_w       = 3
);
  logic                    start;
  logic [addr_w-1:0]       buf_addr;
  logic [buffer_width-1:0] byte_in;
  logic                    byte_in_valid;
  logic                    byte_in_ready;
  logic [buffer_width-1:0] byte_out;
  logic                    byte_out_valid;
  logic                    busy;
  logic                    done;

  modport master (
    output start, buf_addr, byte_in, byte_in_valid,
    input  byte_in_ready, byte_out, byte_out_valid, busy, done
  );

  modport slave (
    input  start, buf_addr, byte_in, byte_in_valid,
    output byte_in_ready, byte_out, byte_out_valid, busy, done
  );
endinterface

// File: rtl/scan_loader.sv
// Scan-chain master: shifts one full pattern buffer in via sclk/sin while
// reassembling the previous chain contents from sout into bytes.
module scan_loader #(
  parameter int buffer_size  = 22,
  parameter int buffer_width = 8,
  parameter int no_bufs      = 8,
  parameter int clk_div      = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  scan_loader_if.slave               host,
  output logic                       sclk,
  output logic                       sin,
  output logic [$clog2(no_bufs)-1:0] saddr,
  input  logic                       sout
);
  localparam int BCW = (buffer_width > 1) ? $clog2(buffer_width) : 1;
  localparam int YCW = (buffer_size  > 1) ? $clog2(buffer_size)  : 1;

  typedef enum logic [2:0] {IDLE, FETCH, LOW, HIGH, FINISH} state_t;

  state_t                  state, state_nx;
  logic [3:0]              div_cnt;
  logic [BCW-1:0]          bit_cnt;
  logic [YCW-1:0]          byte_cnt;
  logic [buffer_width-1:0] tx_sr, rx_sr, byte_out_q;
  logic                    byte_out_vld_q, done_q;
  logic                    div_last, bit_last, byte_last;

  assign div_last  = (div_cnt  == 4'(clk_div - 1));
  assign bit_last  = (bit_cnt  == BCW'(buffer_width - 1));
  assign byte_last = (byte_cnt == YCW'(buffer_size - 1));

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (host.start)         state_nx = FETCH;
      FETCH:   if (host.byte_in_valid) state_nx = LOW;
      LOW:     if (div_last)           state_nx = HIGH;
      HIGH:    if (div_last)           state_nx = !bit_last ? LOW : (byte_last ? FINISH : FETCH);
      FINISH:                          state_nx = IDLE;
      default:                         state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      sclk           <= 1'b0;
      saddr          <= '0;
      div_cnt        <= '0;
      bit_cnt        <= '0;
      byte_cnt       <= '0;
      tx_sr          <= '0;
      rx_sr          <= '0;
      byte_out_q     <= '0;
      byte_out_vld_q <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state          <= state_nx;
      // sclk is a flop tracking the next state, so it never glitches on decode
      sclk           <= (state_nx == HIGH);
      byte_out_vld_q <= 1'b0;
      done_q         <= (state == FINISH);
      case (state)
        IDLE: if (host.start) begin
          saddr    <= host.buf_addr;
          byte_cnt <= '0;
        end
        FETCH: if (host.byte_in_valid) begin
          tx_sr   <= host.byte_in;
          bit_cnt <= '0;
          div_cnt <= '0;
        end
        LOW: begin
          div_cnt <= div_last ? 4'd0 : div_cnt + 4'd1;
          // capture on the same edge that raises sclk, before the chain shifts
          if (div_last) rx_sr <= {rx_sr[buffer_width-2:0], sout};
        end
        HIGH: begin
          div_cnt <= div_last ? 4'd0 : div_cnt + 4'd1;
          if (div_last) begin
            tx_sr   <= {tx_sr[buffer_width-2:0], 1'b0};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_last) begin
              byte_out_q     <= rx_sr;
              byte_out_vld_q <= 1'b1;
              byte_cnt       <= byte_cnt + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign sin                 = tx_sr[buffer_width-1];
  assign host.byte_in_ready  = (state == FETCH);
  assign host.busy           = (state != IDLE);
  assign host.byte_out       = byte_out_q;
  assign host.byte_out_valid = byte_out_vld_q;
  assign host.done           = done_q;
endmodule

// File: doc/scan_loader.md
Name: scan_loader

Overview:
- Serial scan-chain master for the pattern buffer bank.
- Takes a byte stream from the host/config side and generates `sclk`, `sin` and `saddr` to fill one selected 22-byte pattern buffer.
- Captures `sout` at the same time, so the previous contents come back as bytes (non-destructive read-modify-write).
- One transaction always shifts exactly `buffer_size * buffer_width` bits into the addressed chain.

Parameters:
- buffer_size, 22, bytes per pattern buffer chain
- buffer_width, 8, bits per byte
- no_bufs, 8, number of addressable chains (`saddr` width = 3)
- clk_div, 2, `clk` cycles per `sclk` half-period (legal range 1..15)

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  single-cycle request; sampled only in IDLE
- buf_addr  input  3  target chain, captured on accepted start
- byte_in  input  buffer_width  next byte to shift, MSB first
- byte_in_valid  input  1  byte_in holds valid data
- byte_in_ready  output  1  byte accepted when valid&&ready
- byte_out  output  buffer_width  byte reassembled from sout
- byte_out_valid  output  1  one-cycle strobe, no backpressure
- busy  output  1  transaction in progress
- done  output  1  one-cycle strobe at transaction end
- sclk  output  1  scan clock to the buffer bank
- sin  output  1  scan data to the buffer bank
- saddr  output  3  chain select to the buffer bank
- sout  input  1  scan data returned from the selected chain

Behaviour:
- Reset (async, `rst_n` low): state = IDLE. All of these are 0: sclk, sin, saddr, busy, done, byte_in_ready, byte_out, byte_out_valid. All counters are cleared. Reset mid-transaction abandons the shift and forces sclk low immediately; a partially shifted chain is left as-is.
- FSM states: IDLE, FETCH, LOW, HIGH, FINISH.
- IDLE:
  - busy = 0, sclk = 0.
  - On start = 1: latch buf_addr into saddr, clear byte_cnt, set busy, go to FETCH.
- FETCH:
  - byte_in_ready = 1, sclk = 0.
  - On valid&&ready: load the shift register, set bit_cnt = 0, go to LOW.
  - While valid is low, stay in FETCH indefinitely with sclk held low. This stall is legal.
- LOW:
  - sclk = 0 for clk_div cycles; sin = shift register MSB.
  - On the last LOW cycle, sample sout into the capture register LSB, shifting it left.
  - Then go to HIGH.
- HIGH:
  - sclk = 1 for clk_div cycles; sin holds its value.
  - On the last HIGH cycle, shift the transmit register left and increment bit_cnt.
  - If bit_cnt was buffer_width-1: pulse byte_out_valid with the completed capture byte on the next cycle, increment byte_cnt, then:
    - go to FINISH if byte_cnt was buffer_size-1,
    - otherwise go to FETCH.
  - Otherwise go to LOW.
- FINISH:
  - sclk = 0; pulse done for 1 cycle; clear busy; return to IDLE. saddr keeps its last value.
- Timing rules:
  - sclk is registered and glitch-free.
  - saddr and sin change only while sclk = 0, and at least one clk cycle before a rising sclk edge.
  - saddr is stable from the first rising sclk edge to the last falling edge.
- Throughput: one bit = 2·clk_div cycles. With no stalls, one byte = 2·clk_div·buffer_width + 1 cycles (FETCH handshake included).
- start while busy is ignored. No queueing of requests.
- Readback order: the first byte_out holds the first 8 bits that leave the chain. The bank sees exactly buffer_size·buffer_width rising sclk edges per transaction, so after a full transaction byte_out in order equals the prior chain contents.
- byte_in_ready is asserted only in FETCH, so at most one byte is held internally.

Test Plan:
- Full load, clk_div = 2: start with buf_addr = 3, bytes 0x00..0x15, chain model pre-filled with 0xA5 → saddr = 3, exactly 176 rising sclk edges, chain ends with 0x00..0x15, 22 byte_out values all 0xA5, done 1 cycle after the last falling edge, total 22·33 + 3 cycles.
- Round trip: two back-to-back transactions to chain 7, second one with all 0xFF → second readback equals the first write stream byte-for-byte; chain 0 model is never clocked.
- Input stall: drop byte_in_valid for 10 cycles after byte 5 → sclk stays low throughout, no extra edges, final contents correct, busy stays 1.
- start pulsed while busy with buf_addr = 1 → ignored; saddr stays at the original value, transaction count unchanged.
- rst_n low mid-bit (in HIGH, byte 9) → sclk, busy, done and byte_in_ready all 0 asynchronously; after release, a new transaction to chain 2 completes normally.
- clk_div = 1 → sclk period is 2 clk cycles; sin is stable before each rising edge; data integrity as in the full-load scenario.
